// File: rtl/spi_fifo_pkg.sv
// Shared definitions for the SPI frame FIFO: parameter limits, clog2 and the level-compare helper.
package spi_fifo_pkg;

  localparam int FRAME_MIN = 4;
  localparam int FRAME_MAX = 32;
  localparam int DEPTH_MIN = 2;
  localparam int DEPTH_MAX = 256;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Unsigned "a >= b" on zero-extended operands of any width up to 32 bits.
  function automatic logic level_ge(input logic [31:0] a, input logic [31:0] b);
    return a >= b;
  endfunction

endpackage

// File: rtl/spi_fifo_ram.sv
// Storage array for the SPI frame FIFO: one write port, asynchronous read, no reset.
module spi_fifo_ram #(
  parameter int W     = 9,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [PW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array is deliberately not reset; a reset would turn it into flops and adds nothing, since empty hides the contents.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/spi_fifo_prog.sv
// Synchronous FIFO, any depth 2..256, with programmable levels and sticky status.
// Optional high-water mark register enabled by defining SPI_FIFO_HWM_EN.
module spi_fifo_prog
  import spi_fifo_pkg::*;
#(
  parameter  int CFG_FRAME_SIZE = 8,
  parameter  int CFG_FIFO_DEPTH = 8,
  localparam int CW = clog2(CFG_FIFO_DEPTH + 1),
  localparam int PW = (clog2(CFG_FIFO_DEPTH) > 1) ? clog2(CFG_FIFO_DEPTH) : 1
) (
  input  logic                      pclk,
  input  logic                      sreset,
  input  logic                      fiforst,
  input  logic [CFG_FRAME_SIZE-1:0] data_in,
  input  logic                      flag_in,
  input  logic                      write_in,
  input  logic                      read_in,
  input  logic [CW-1:0]             afull_level,
  input  logic [CW-1:0]             aempty_level,
  input  logic                      status_clr,
  output logic [CFG_FRAME_SIZE-1:0] data_out,
  output logic                      flag_out,
  output logic                      full_out,
  output logic                      empty_out,
  output logic                      afull_out,
  output logic                      aempty_out,
  output logic                      overflow_out,
  output logic                      underflow_out,
  output logic                      ovf_sticky,
  output logic                      udf_sticky,
  output logic [CW-1:0]             fifo_count,
  output logic [CW-1:0]             hwm_count
);

  if (CFG_FRAME_SIZE < FRAME_MIN || CFG_FRAME_SIZE > FRAME_MAX ||
      CFG_FIFO_DEPTH < DEPTH_MIN || CFG_FIFO_DEPTH > DEPTH_MAX) begin : g_bad_cfg
    $error("spi_fifo_prog: CFG_FRAME_SIZE or CFG_FIFO_DEPTH out of range");
  end

  localparam logic [CW-1:0] DEPTH_C  = CW'(CFG_FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(CFG_FIFO_DEPTH - 1);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          full_q, empty_q, ovf_q, udf_q;
  logic          rd_acc, wr_acc;
  logic [CFG_FRAME_SIZE:0] rdata;

  // Explicit wrap so non-power-of-two depths cycle through exactly DEPTH slots.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  assign rd_acc        = read_in && (count_q != '0);
  assign wr_acc        = write_in && ((count_q != DEPTH_C) || rd_acc);
  assign overflow_out  = write_in && !wr_acc;
  assign underflow_out = read_in && (count_q == '0);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fiforst) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = next_ptr(wr_ptr_q);
      if (rd_acc) rd_ptr_d = next_ptr(rd_ptr_q);
      if (wr_acc && !rd_acc) count_d = count_q + CW'(1);
      else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge pclk) begin
    if (sreset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      full_q   <= (count_d == DEPTH_C);
      empty_q  <= (count_d == '0);
      ovf_q    <= overflow_out || (ovf_q && !status_clr);
      udf_q    <= underflow_out || (udf_q && !status_clr);
    end
  end

  spi_fifo_ram #(
    .W     (CFG_FRAME_SIZE + 1),
    .DEPTH (CFG_FIFO_DEPTH),
    .PW    (PW)
  ) u_ram (
    .clk_i   (pclk),
    .we_i    (wr_acc && !fiforst),
    .waddr_i (wr_ptr_q),
    .wdata_i ({flag_in, data_in}),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign data_out   = rdata[CFG_FRAME_SIZE-1:0];
  assign flag_out   = rdata[CFG_FRAME_SIZE] && !empty_q;
  assign full_out   = full_q;
  assign empty_out  = empty_q;
  assign fifo_count = count_q;
  assign ovf_sticky = ovf_q;
  assign udf_sticky = udf_q;
  assign afull_out  = level_ge(32'(count_q), 32'(afull_level));
  assign aempty_out = level_ge(32'(aempty_level), 32'(count_q));

`ifdef SPI_FIFO_HWM_EN
  logic [CW-1:0] hwm_q, hwm_d;

  // A status clear restarts tracking from the occupancy at the time of the clear.
  always_comb begin
    hwm_d = hwm_q;
    if (status_clr) hwm_d = count_q;
    else if (count_d > hwm_q) hwm_d = count_d;
  end

  always_ff @(posedge pclk) begin
    if (sreset) hwm_q <= '0;
    else        hwm_q <= hwm_d;
  end

  assign hwm_count = hwm_q;
`else
  assign hwm_count = '0;
`endif

endmodule
